// File: rtl/baopoco_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : baopoco_capture_ctrl
// Brief    : ADC snapshot sequencer: decodes the PPC control word into
//            arm/trigger/abort commands and writes a bounded sample burst to
//            BRAM. Optional macro CAPTURE_TSTAMP_EN adds a trigger timestamp.
// Revision : 1.0  initial release
// ============================================================================
module baopoco_capture_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic [31:0]       ctrl_word,
    input  logic              ext_trig,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic [31:0]       status_word,
`ifdef CAPTURE_TSTAMP_EN
    output logic [31:0]       trig_tstamp,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [16:0] c_max_len = 17'((1 << ADDR_W) - 1);

    state_t              state_q, state_d;
    logic [3:0]          ctrl_q;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                clamp_q, clamp_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;

    logic                arm_edge, trig_edge, abort_edge;
    logic                clamp_sel;
    logic [ADDR_W-1:0]   len_sel;
    logic                unused_ctrl;

    assign arm_edge    = ctrl_word[0] & ~ctrl_q[0];
    assign trig_edge   = ctrl_word[2] & ~ctrl_q[2];
    assign abort_edge  = ctrl_word[3] & ~ctrl_q[3];
    assign unused_ctrl = ^{ctrl_word[15:4], ctrl_q[1]};

    // Requested lengths beyond the buffer depth are clamped to the last address.
    assign clamp_sel = {1'b0, ctrl_word[31:16]} > c_max_len;
    assign len_sel   = clamp_sel ? {ADDR_W{1'b1}} : ADDR_W'(ctrl_word[31:16]);

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= 4'd0;
            len_q   <= '0;
            clamp_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_word[3:0];
            len_q   <= len_d;
            clamp_q <= clamp_d;
            done_q  <= done_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        clamp_d = clamp_q;
        done_d  = done_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_edge && !abort_edge) begin
                    state_d = ST_ARMED;
                    len_d   = len_sel;
                    clamp_d = clamp_sel;
                    done_d  = 1'b0;
                    count_d = '0;
                    addr_d  = '0;
                end
            end
            ST_ARMED: begin
                if (abort_edge) begin
                    state_d = ST_IDLE;
                end else if (!ctrl_word[1] || ext_trig || trig_edge) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A sample presented on the abort cycle is dropped; the write
                // already on the BRAM port still completes.
                if (abort_edge) begin
                    state_d = ST_IDLE;
                end else if (adc_valid) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    din_d   = adc_data;
                    count_d = count_q + 1'b1;
                    if (count_q[ADDR_W-1:0] == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef CAPTURE_TSTAMP_EN
    logic [31:0] tcnt_q;
    logic [31:0] tstamp_q;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            tcnt_q   <= 32'd0;
            tstamp_q <= 32'd0;
        end else begin
            tcnt_q <= tcnt_q + 32'd1;
            if (state_q == ST_ARMED && state_d == ST_CAPTURE) begin
                tstamp_q <= tcnt_q;
            end
        end
    end

    assign trig_tstamp = tstamp_q;
`endif

    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_din    = din_q;
    assign status_word = {16'(count_q), 12'd0, clamp_q, done_q, state_q};
    assign busy        = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

endmodule
`default_nettype wire
